// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset core.
// Holds the FSM state type, ALU operation type, decoded instruction kinds,
// the opcode/funct constants, and the decode/immediate helper functions.
package core_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_IDX_W = 5;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 / funct7 values of the supported subset
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    PASS_B
  } alu_op_t;

  typedef enum logic [3:0] {
    I_ADD,
    I_SUB,
    I_ADDI,
    I_LUI,
    I_LW,
    I_SW,
    I_BEQ,
    I_BNE,
    I_JAL,
    I_ILLEGAL
  } instr_t;

  // Classify an instruction; anything outside the subset is I_ILLEGAL.
  function automatic instr_t decode_instr(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
    instr_t kind;
    kind = I_ILLEGAL;
    case (opcode)
      OP_R: begin
        if (funct3 == F3_ADD_SUB) begin
          if (funct7 == F7_BASE) kind = I_ADD;
          else if (funct7 == F7_SUB) kind = I_SUB;
        end
      end
      OP_I:      if (funct3 == F3_ADD_SUB) kind = I_ADDI;
      OP_LOAD:   if (funct3 == F3_WORD) kind = I_LW;
      OP_STORE:  if (funct3 == F3_WORD) kind = I_SW;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) kind = I_BEQ;
        else if (funct3 == F3_BNE) kind = I_BNE;
      end
      OP_LUI:    kind = I_LUI;
      OP_JAL:    kind = I_JAL;
      default:   kind = I_ILLEGAL;
    endcase
    return kind;
  endfunction

  // Sign-extended immediate selected by instruction format (U is pre-shifted).
  function automatic logic [31:0] gen_imm(input logic [31:0] ir);
    logic [31:0] imm;
    imm = '0;
    case (ir[6:0])
      OP_I, OP_LOAD: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:     imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI:        imm = {ir[31:12], 12'b0};
      OP_JAL:        imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default:       imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for the multicycle core.
// Ports: op (ADD/SUB/PASS_B), a, b operands; result, and zero (result == 0).
module core_alu
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  always_comb begin
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      PASS_B:  result = b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core (ADD, SUB, ADDI, LUI, LW, SW, BEQ, BNE, JAL)
// sequenced FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK], with a
// sticky TRAP state for illegal or misaligned operations.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   mem_req/mem_we  unified memory request (read or store), held until mem_ready
//   mem_addr        byte address (low ADDRESS_WIDTH bits)
//   mem_wdata       store data; mem_rdata read data valid with mem_ready
//   a0              live value of register x10
//   trap            core halted
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     trap
);

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Instruction fields
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] rd;
  instr_t               instr;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign instr  = decode_instr(opcode, funct3, funct7);

  // Datapath
  alu_op_t               alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_target;
  logic                  br_taken;
  logic [DATA_WIDTH-1:0] br_next;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] wb_pc;
  logic                  rf_we;

  assign pc_plus4  = pc + DATA_WIDTH'(4);
  assign pc_target = pc + imm;
  // Branch compare reuses the ALU subtract; zero means rs1 == rs2
  assign br_taken  = (instr == I_BEQ) ? alu_zero : !alu_zero;
  assign br_next   = br_taken ? pc_target : pc_plus4;
  assign wb_data   = (instr == I_LW) ? mdr : alu_out;
  // JAL already moved the PC in EXECUTE
  assign wb_pc     = (instr == I_JAL) ? pc : pc_plus4;
  assign rf_we     = (state == WRITEBACK) && (rd != '0);
  assign a0        = regs[10];

  // ALU operand and operation select
  always_comb begin
    alu_op = ADD;
    alu_a  = a_reg;
    alu_b  = imm;
    case (instr)
      I_ADD: alu_b = b_reg;
      I_SUB: begin
        alu_op = SUB;
        alu_b  = b_reg;
      end
      I_LUI: alu_op = PASS_B;
      I_BEQ, I_BNE: begin
        alu_op = SUB;
        alu_b  = b_reg;
      end
      I_JAL: begin
        alu_a = pc;
        alu_b = DATA_WIDTH'(4);
      end
      default: ;
    endcase
  end

  core_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Register file: asynchronous read, clocked write; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rd] <= wb_data;
    end
  end

  // Control FSM with registered memory-port and trap outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      imm       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      trap      <= 1'b0;
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC[ADDRESS_WIDTH-1:0];
      mem_wdata <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end

        DECODE: begin
          a_reg <= regs[rs1];
          b_reg <= regs[rs2];
          imm   <= gen_imm(ir);
          state <= EXECUTE;
        end

        EXECUTE: begin
          case (instr)
            I_ADD, I_SUB, I_ADDI, I_LUI: begin
              alu_out <= alu_result;
              state   <= WRITEBACK;
            end
            I_LW, I_SW: begin
              alu_out <= alu_result;
              if (alu_result[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= (instr == I_SW);
                mem_addr  <= alu_result[ADDRESS_WIDTH-1:0];
                mem_wdata <= b_reg;
                state     <= MEM;
              end
            end
            I_BEQ, I_BNE: begin
              if (br_taken && (pc_target[1:0] != 2'b00)) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                pc       <= br_next;
                mem_req  <= 1'b1;
                mem_addr <= br_next[ADDRESS_WIDTH-1:0];
                state    <= FETCH;
              end
            end
            I_JAL: begin
              if (pc_target[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                alu_out <= alu_result;
                pc      <= pc_target;
                state   <= WRITEBACK;
              end
            end
            default: begin
              trap  <= 1'b1;
              state <= TRAP;
            end
          endcase
        end

        MEM: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (instr == I_LW) begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= WRITEBACK;
            end else begin
              // Store done: request stays up and turns into the next fetch
              pc       <= pc_plus4;
              mem_addr <= pc_plus4[ADDRESS_WIDTH-1:0];
              state    <= FETCH;
            end
          end
        end

        WRITEBACK: begin
          pc       <= wb_pc;
          mem_req  <= 1'b1;
          mem_addr <= wb_pc[ADDRESS_WIDTH-1:0];
          state    <= FETCH;
        end

        TRAP: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          trap    <= 1'b1;
        end

        default: begin
          mem_req <= 1'b0;
          trap    <= 1'b1;
          state   <= TRAP;
        end
      endcase
    end
  end

endmodule
